// File: rtl/neopixel_pkg.sv
// Shared constants for the NeoPixel frame buffer: byte lanes, FSM states, pixel width.
// Pure definitions, no logic; imported by the bank and the top.
package neopixel_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [1:0] BYTE_GREEN = 2'd0;
  localparam logic [1:0] BYTE_RED   = 2'd1;
  localparam logic [1:0] BYTE_BLUE  = 2'd2;

  localparam logic [PIXEL_W-1:0] DEFAULT_COLOR_DEF = 24'h101010;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_PENDING = 2'd1,
    STATE_COPY    = 2'd2
  } state_t;

  // One-hot lane enable for a host byte select; the reserved select enables nothing.
  function automatic logic [2:0] byte_mask(input logic [1:0] sel);
    logic [2:0] m;
    m = 3'b000;
    case (sel)
      BYTE_GREEN: m = 3'b001;
      BYTE_RED:   m = 3'b010;
      BYTE_BLUE:  m = 3'b100;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/neopixel_pixel_bank.sv
// PIXELS_MAX x 24-bit pixel store: one byte-masked write port (1-cycle), one combinational read port.
// No backpressure; out-of-range writes are dropped and out-of-range reads return zero.
module neopixel_pixel_bank
  import neopixel_pkg::*;
#(
  parameter int PIXELS_MAX  = 3,
  parameter int PIXELS_BITS = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_vld,
  input  logic [PIXELS_BITS-1:0] i_wr_idx,
  input  logic [2:0]             i_wr_mask,
  input  logic [PIXEL_W-1:0]     i_wr_dat,
  input  logic [PIXELS_BITS-1:0] i_rd_idx,
  output logic [PIXEL_W-1:0]     o_rd_dat
);

  logic [PIXEL_W-1:0] r_mem [PIXELS_MAX];
  logic               w_wr_in_range;
  logic               w_rd_in_range;

  assign w_wr_in_range = int'(i_wr_idx) < PIXELS_MAX;
  assign w_rd_in_range = int'(i_rd_idx) < PIXELS_MAX;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < PIXELS_MAX; p++) begin
        r_mem[p] <= '0;
      end
    end else if (i_wr_vld && w_wr_in_range) begin
      for (int b = 0; b < 3; b++) begin
        if (i_wr_mask[b]) begin
          r_mem[i_wr_idx][b*8 +: 8] <= i_wr_dat[b*8 +: 8];
        end
      end
    end
  end

  assign o_rd_dat = w_rd_in_range ? r_mem[i_rd_idx] : '0;

endmodule

// File: rtl/neopixel_frame_buffer.sv
// Double-buffered pixel store: host bytes land in the back bank, COMMIT copies back->front during the serializer latch gap.
// Read latency 1 cycle; BUS_READY is held low only while the PIXELS_MAX-cycle copy runs.
module neopixel_frame_buffer
  import neopixel_pkg::*;
#(
  parameter int                 PIXELS_MAX    = 3,
  parameter int                 PIXELS_BITS   = 2,
  parameter logic [PIXEL_W-1:0] DEFAULT_COLOR = DEFAULT_COLOR_DEF
) (
  input  logic                   CLK_10MHZ,
  input  logic                   RESET_N,
  input  logic [PIXELS_BITS+1:0] BUS_ADDR,
  input  logic [7:0]             BUS_DATA,
  input  logic                   BUS_VALID,
  output logic                   BUS_READY,
  input  logic                   COMMIT,
  output logic                   COMMIT_PENDING,
  input  logic                   STREAM_IDLE,
  output logic                   FRAME_HOLD,
  input  logic [PIXELS_BITS-1:0] PIXEL_INDEX,
  output logic [PIXEL_W-1:0]     PIXEL_VALUE
);

  localparam logic [PIXELS_BITS-1:0] LAST_IDX = PIXELS_BITS'(PIXELS_MAX - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PIXELS_BITS-1:0] r_cnt;
  logic [PIXELS_BITS-1:0] w_cnt_nxt;
  logic                   r_again;
  logic                   w_again_nxt;
  logic                   r_bus_ready;
  logic                   r_frame_hold;
  logic [PIXEL_W-1:0]     r_pixel_value;

  logic [PIXELS_BITS-1:0] w_bus_pix;
  logic [1:0]             w_bus_sel;
  logic [2:0]             w_back_mask;
  logic                   w_bus_acc;
  logic                   w_back_wr_vld;
  logic                   w_copy_vld;
  logic                   w_rd_in_range;
  logic [PIXEL_W-1:0]     w_back_rd_dat;
  logic [PIXEL_W-1:0]     w_front_rd_dat;

  assign w_bus_pix     = BUS_ADDR[PIXELS_BITS+1:2];
  assign w_bus_sel     = BUS_ADDR[1:0];
  assign w_back_mask   = byte_mask(w_bus_sel);
  assign w_bus_acc     = BUS_VALID && r_bus_ready;
  // Out-of-range pixels and the reserved lane still complete the handshake; the mask/range drop the data.
  assign w_back_wr_vld = w_bus_acc && (int'(w_bus_pix) < PIXELS_MAX);
  assign w_copy_vld    = (r_state == STATE_COPY);
  assign w_rd_in_range = int'(PIXEL_INDEX) < PIXELS_MAX;

  neopixel_pixel_bank #(
    .PIXELS_MAX (PIXELS_MAX),
    .PIXELS_BITS(PIXELS_BITS)
  ) u_back (
    .i_clk    (CLK_10MHZ),
    .i_rst_n  (RESET_N),
    .i_wr_vld (w_back_wr_vld),
    .i_wr_idx (w_bus_pix),
    .i_wr_mask(w_back_mask),
    .i_wr_dat ({3{BUS_DATA}}),
    .i_rd_idx (r_cnt),
    .o_rd_dat (w_back_rd_dat)
  );

  neopixel_pixel_bank #(
    .PIXELS_MAX (PIXELS_MAX),
    .PIXELS_BITS(PIXELS_BITS)
  ) u_front (
    .i_clk    (CLK_10MHZ),
    .i_rst_n  (RESET_N),
    .i_wr_vld (w_copy_vld),
    .i_wr_idx (r_cnt),
    .i_wr_mask(3'b111),
    .i_wr_dat (w_back_rd_dat),
    .i_rd_idx (PIXEL_INDEX),
    .o_rd_dat (w_front_rd_dat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_again_nxt = r_again;
    case (r_state)
      STATE_IDLE: begin
        if (COMMIT) begin
          w_state_nxt = STATE_PENDING;
        end
      end
      STATE_PENDING: begin
        if (STREAM_IDLE) begin
          w_state_nxt = STATE_COPY;
          w_cnt_nxt   = '0;
          w_again_nxt = 1'b0;
        end
      end
      STATE_COPY: begin
        w_again_nxt = r_again || COMMIT;
        if (r_cnt == LAST_IDX) begin
          // A commit seen at any point of the copy, including its last cycle, queues another copy.
          w_state_nxt = (r_again || COMMIT) ? STATE_PENDING : STATE_IDLE;
          w_cnt_nxt   = '0;
          w_again_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + PIXELS_BITS'(1);
        end
      end
      default: begin
        w_state_nxt = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= STATE_IDLE;
      r_cnt        <= '0;
      r_again      <= 1'b0;
      r_bus_ready  <= 1'b1;
      r_frame_hold <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_again      <= w_again_nxt;
      r_bus_ready  <= (w_state_nxt != STATE_COPY);
      r_frame_hold <= (w_state_nxt == STATE_COPY);
    end
  end

  always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pixel_value <= '0;
    end else begin
      r_pixel_value <= w_rd_in_range ? w_front_rd_dat : DEFAULT_COLOR;
    end
  end

  assign BUS_READY      = r_bus_ready;
  assign FRAME_HOLD     = r_frame_hold;
  assign COMMIT_PENDING = (r_state != STATE_IDLE);
  assign PIXEL_VALUE    = r_pixel_value;

endmodule

// File: tb/tb_neopixel_frame_buffer.sv
// Bench for neopixel_frame_buffer: directed scenarios plus randomized traffic against a frame-level model.
module tb_neopixel_frame_buffer;

  localparam int          NPIX = 3;
  localparam logic [23:0] DEF  = 24'h101010;

  logic        CLK_10MHZ = 1'b0;
  logic        RESET_N = 1'b0;
  logic [3:0]  BUS_ADDR = '0;
  logic [7:0]  BUS_DATA = '0;
  logic        BUS_VALID = 1'b0;
  logic        BUS_READY;
  logic        COMMIT = 1'b0;
  logic        COMMIT_PENDING;
  logic        STREAM_IDLE = 1'b0;
  logic        FRAME_HOLD;
  logic [1:0]  PIXEL_INDEX = '0;
  logic [23:0] PIXEL_VALUE;

  int checks = 0;
  int failures = 0;

  neopixel_frame_buffer dut (
    .CLK_10MHZ     (CLK_10MHZ),
    .RESET_N       (RESET_N),
    .BUS_ADDR      (BUS_ADDR),
    .BUS_DATA      (BUS_DATA),
    .BUS_VALID     (BUS_VALID),
    .BUS_READY     (BUS_READY),
    .COMMIT        (COMMIT),
    .COMMIT_PENDING(COMMIT_PENDING),
    .STREAM_IDLE   (STREAM_IDLE),
    .FRAME_HOLD    (FRAME_HOLD),
    .PIXEL_INDEX   (PIXEL_INDEX),
    .PIXEL_VALUE   (PIXEL_VALUE)
  );

  always #50 CLK_10MHZ = ~CLK_10MHZ;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {23'd0, act}, {23'd0, exp});
  endtask

  // Frame-level model: pixel arrays, an outstanding-commit flag and a count of copy cycles left.
  logic [23:0] mb [NPIX];
  logic [23:0] mf [NPIX];
  logic [23:0] exp_pix = '0;
  bit          exp_ready = 1'b1;
  bit          exp_hold = 1'b0;
  bit          exp_cpend = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_again = 1'b0;
  bit          m_acc = 1'b0;
  int          m_left = 0;

  always @(posedge CLK_10MHZ or negedge RESET_N) begin : model
    int pix;
    int sel;
    int k;
    if (!RESET_N) begin
      for (int i = 0; i < NPIX; i++) begin
        mb[i] = '0;
        mf[i] = '0;
      end
      exp_pix = '0; exp_ready = 1'b1; exp_hold = 1'b0; exp_cpend = 1'b0;
      m_pend = 1'b0; m_again = 1'b0; m_left = 0; m_acc = 1'b0;
    end else begin
      pix = int'(BUS_ADDR[3:2]);
      sel = int'(BUS_ADDR[1:0]);
      if (int'(PIXEL_INDEX) < NPIX) exp_pix = mf[PIXEL_INDEX];
      else exp_pix = DEF;
      m_acc = BUS_VALID && exp_ready;
      if (m_acc && pix < NPIX && sel < 3) mb[pix][sel*8 +: 8] = BUS_DATA;
      if (m_left > 0) begin
        k = NPIX - m_left;
        mf[k] = mb[k];
        if (COMMIT) m_again = 1'b1;
        m_left--;
        if (m_left == 0 && m_again) begin
          m_pend = 1'b1;
          m_again = 1'b0;
        end
      end else if (m_pend) begin
        if (STREAM_IDLE) begin
          m_left = NPIX;
          m_pend = 1'b0;
        end
      end else if (COMMIT) begin
        m_pend = 1'b1;
      end
      exp_ready = (m_left == 0);
      exp_hold  = (m_left > 0);
      exp_cpend = m_pend || (m_left > 0);
    end
  end

  always @(negedge CLK_10MHZ) begin
    if (RESET_N) begin
      check("cyc_pixel_value", PIXEL_VALUE, exp_pix);
      check1("cyc_bus_ready", BUS_READY, exp_ready);
      check1("cyc_frame_hold", FRAME_HOLD, exp_hold);
      check1("cyc_commit_pending", COMMIT_PENDING, exp_cpend);
    end
  end

  task automatic tick();
    @(negedge CLK_10MHZ);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    int t;
    bit rdy;
    BUS_ADDR = a; BUS_DATA = d; BUS_VALID = 1'b1;
    t = 0; rdy = 1'b0;
    while (t < 100) begin
      rdy = BUS_READY;
      tick();
      if (rdy) break;
      t++;
    end
    BUS_VALID = 1'b0;
    check1("bus_handshake", rdy, 1'b1);
  endtask

  task automatic pulse_commit();
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
  endtask

  task automatic wait_hold_rise();
    int t;
    t = 0;
    while (!FRAME_HOLD && t < 200) begin
      tick();
      t++;
    end
    check1("hold_rise_timeout", FRAME_HOLD, 1'b1);
  endtask

  task automatic wait_hold_fall(output int n);
    n = 0;
    while (FRAME_HOLD && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic read_pixel(input string name, input logic [1:0] idx, input logic [23:0] exp);
    PIXEL_INDEX = idx;
    tick();
    check(name, PIXEL_VALUE, exp);
  endtask

  initial begin : main
    int n;
    int lows;
    logic [23:0] want;
    repeat (3) tick();
    RESET_N = 1'b1;

    // Reset contents and the out-of-range default colour
    for (int i = 0; i < 4; i++) begin
      want = (i < NPIX) ? 24'h000000 : DEF;
      read_pixel("reset_read", 2'(i), want);
    end
    check1("reset_bus_ready", BUS_READY, 1'b1);
    check1("reset_commit_pending", COMMIT_PENDING, 1'b0);
    check1("reset_frame_hold", FRAME_HOLD, 1'b0);

    // Back-bank writes are invisible until committed
    bus_write(4'h0, 8'hD5);
    bus_write(4'h1, 8'h00);
    bus_write(4'h2, 8'hFF);
    read_pixel("front_before_commit", 2'd0, 24'h000000);
    STREAM_IDLE = 1'b1;
    pulse_commit();
    wait_hold_rise();
    wait_hold_fall(n);
    check("hold_length", 24'(n), 24'd3);
    check("pix0_after_commit", PIXEL_VALUE, 24'hFF00D5);

    // Commit parked while the serializer is busy; writes keep flowing
    STREAM_IDLE = 1'b0;
    pulse_commit();
    repeat (50) tick();
    check1("parked_pending", COMMIT_PENDING, 1'b1);
    check1("parked_no_hold", FRAME_HOLD, 1'b0);
    bus_write(4'h8, 8'h12);
    bus_write(4'h9, 8'h34);
    bus_write(4'hA, 8'h56);
    STREAM_IDLE = 1'b1;
    tick();
    check1("hold_next_cycle", FRAME_HOLD, 1'b1);
    wait_hold_fall(n);
    read_pixel("pix2_parked_writes", 2'd2, 24'h563412);

    // Write stalled by the copy plus a recommit mid-copy
    pulse_commit();
    wait_hold_rise();
    BUS_ADDR = 4'h5; BUS_DATA = 8'h88; BUS_VALID = 1'b1; COMMIT = 1'b1;
    lows = 0;
    while (!BUS_READY && lows < 20) begin
      lows++;
      tick();
      COMMIT = 1'b0;
    end
    check("ready_low_cycles", 24'(lows), 24'd3);
    check1("recommit_pending", COMMIT_PENDING, 1'b1);
    tick();
    BUS_VALID = 1'b0;
    check1("second_copy_hold", FRAME_HOLD, 1'b1);
    wait_hold_fall(n);
    read_pixel("pix1_second_copy", 2'd1, 24'h008800);

    // Out-of-range pixel and reserved byte lane are swallowed
    bus_write(4'hC, 8'hAA);
    bus_write(4'h3, 8'hBB);
    pulse_commit();
    wait_hold_rise();
    wait_hold_fall(n);
    read_pixel("discard_pix0", 2'd0, 24'hFF00D5);
    read_pixel("discard_pix1", 2'd1, 24'h008800);
    read_pixel("discard_pix2", 2'd2, 24'h563412);
    read_pixel("discard_pix3", 2'd3, DEF);

    // Reset in the second copy cycle
    PIXEL_INDEX = 2'd0;
    pulse_commit();
    wait_hold_rise();
    tick();
    RESET_N = 1'b0;
    #1;
    check("midcopy_rst_pixel", PIXEL_VALUE, 24'h000000);
    check1("midcopy_rst_ready", BUS_READY, 1'b1);
    check1("midcopy_rst_pending", COMMIT_PENDING, 1'b0);
    check1("midcopy_rst_hold", FRAME_HOLD, 1'b0);
    tick();
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want = (i < NPIX) ? 24'h000000 : DEF;
      read_pixel("post_rst_front", 2'(i), want);
    end
    pulse_commit();
    wait_hold_rise();
    wait_hold_fall(n);
    for (int i = 0; i < NPIX; i++) begin
      read_pixel("post_rst_back", 2'(i), 24'h000000);
    end

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 800; c++) begin
      if (!BUS_VALID || m_acc) begin
        BUS_VALID = 1'($urandom_range(0, 1));
        BUS_ADDR  = 4'($urandom_range(0, 15));
        BUS_DATA  = 8'($urandom);
      end
      COMMIT = !COMMIT && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) STREAM_IDLE = 1'($urandom_range(0, 1));
      PIXEL_INDEX = 2'($urandom_range(0, 3));
      tick();
    end
    BUS_VALID = 1'b0;
    COMMIT = 1'b0;
    STREAM_IDLE = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < NPIX; i++) begin
      read_pixel("final_front", 2'(i), mf[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
